fsk_modulator: RTL and testbench

//  Continuous-phase binary FSK transmitter driven by mainclk, the main clock

---
 rtl/fsk_modulator_if.sv | 11 +
 rtl/fsk_modulator.sv | 128 ++++++++++++
 tb/tb_fsk_modulator.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fsk_modulator_if.sv
// rtl/fsk_modulator_if.sv - byte handshake between the frame source and the FSK transmitter
interface fsk_modulator_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/fsk_modulator.sv
// rtl/fsk_modulator.sv - continuous-phase binary FSK transmitter with UART-style framing
module fsk_modulator #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 288,
  parameter int PHASE_W    = 16,
  parameter int FW_SPACE   = 2048,
  parameter int FW_MARK    = 4096
) (
  input  logic                 mainclk,
  input  logic                 reset,
  fsk_modulator_if.slave       tx,
  output logic                 bit_cur,
  output logic                 busy,
  output logic [PHASE_W-1:0]   phase,
  output logic                 fsk_out
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                bit_q, bit_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic                last_cyc;
  logic                ready;
  logic                accept;

  always_ff @(posedge mainclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      bit_q   <= 1'b1;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    last_cyc = (cnt_q == CNT_LAST);
    // The last stop cycle also accepts, so back-to-back frames have no idle gap
    ready    = (state_q == S_IDLE) || ((state_q == S_STOP) && last_cyc);
    accept   = tx.tx_valid && ready;

    if (state_q != S_IDLE) begin
      cnt_d = last_cyc ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          shreg_d = tx.tx_data;
          bit_d   = 1'b0;
        end
      end
      S_START: begin
        if (last_cyc) begin
          state_d = S_DATA;
          idx_d   = '0;
          bit_d   = shreg_q[0];
        end
      end
      S_DATA: begin
        if (last_cyc) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
            bit_d   = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            bit_d   = shreg_q[1];
          end
        end
      end
      S_STOP: begin
        if (last_cyc) begin
          if (accept) begin
            state_d = S_START;
            shreg_d = tx.tx_data;
            bit_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            bit_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        bit_d   = 1'b1;
      end
    endcase

    // Tone follows the registered symbol; phase is never cleared, wrapping mod 2^PHASE_W
    phase_d = phase_q + (bit_q ? PHASE_W'(FW_MARK) : PHASE_W'(FW_SPACE));
  end

  assign tx.tx_ready = ready;
  assign bit_cur     = bit_q;
  assign busy        = (state_q != S_IDLE);
  assign phase       = phase_q;
  assign fsk_out     = phase_q[PHASE_W-1];

endmodule

// File: tb/tb_fsk_modulator.sv
// tb/tb_fsk_modulator.sv - randomized bench for fsk_modulator against a symbol-queue reference model
module tb_fsk_modulator;

  localparam int BITC = 288;
  localparam int FRAME = 10 * BITC;

  logic        mainclk = 1'b0;
  logic        reset;
  logic        bit_cur, busy, fsk_out;
  logic [15:0] phase;

  fsk_modulator_if #(.DATA_W(8)) txif ();

  fsk_modulator dut (
    .mainclk (mainclk),
    .reset   (reset),
    .tx      (txif),
    .bit_cur (bit_cur),
    .busy    (busy),
    .phase   (phase),
    .fsk_out (fsk_out)
  );

  always #5 mainclk = ~mainclk;

  // Reference model: queue of symbols still to send in the current frame
  bit          sym_q[$];
  int          left;
  logic [15:0] m_phase;
  logic        m_bit, m_busy, m_ready, m_acc;
  logic [19:0] s_vec, e_vec;
  int          vec_bad;
  int          checks = 0;
  int          errors = 0;

  task automatic model_reset();
    sym_q.delete();
    left    = 0;
    m_phase = 16'h0000;
  endtask

  // Sample DUT mid-cycle, compare to model prediction, then advance both one clock
  task automatic tick();
    @(negedge mainclk);
    m_busy  = (sym_q.size() != 0);
    m_bit   = m_busy ? sym_q[0] : 1'b1;
    m_ready = !m_busy || (sym_q.size() == 1 && left == 1);
    s_vec   = {bit_cur, busy, txif.tx_ready, fsk_out, phase};
    e_vec   = {m_bit, m_busy, m_ready, m_phase[15], m_phase};
    if (s_vec !== e_vec) begin
      if (vec_bad < 3)
        $display("FAIL cycle_vector: got %h expected %h", s_vec, e_vec);
      vec_bad++;
    end
    m_acc = txif.tx_valid && m_ready;
    @(posedge mainclk);
    m_phase = m_phase + (m_bit ? 16'd4096 : 16'd2048);
    if (m_busy) begin
      left--;
      if (left == 0) begin
        void'(sym_q.pop_front());
        left = BITC;
      end
    end
    if (m_acc) begin
      sym_q.delete();
      sym_q.push_back(1'b0);
      for (int k = 0; k < 8; k++) sym_q.push_back(txif.tx_data[k]);
      sym_q.push_back(1'b1);
      left = BITC;
    end
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    txif.tx_valid = 1'b1;
    txif.tx_data  = b;
    tick();
    txif.tx_valid = 1'b0;
    txif.tx_data  = 8'($urandom);
  endtask

  // Records symbol levels at the middle of each symbol of one frame
  task automatic capture(output logic [9:0] syms, output int rdy_low, output int busy_n);
    syms = '0; rdy_low = 0; busy_n = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      tick();
      if (i < FRAME && (i % BITC) == BITC / 2) syms[i / BITC] = s_vec[19];
      if (!s_vec[17]) rdy_low++;
      if (s_vec[18]) busy_n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    txif.tx_valid = 1'b0;
    txif.tx_data  = 8'h00;
    #3;
    checks++; if (bit_cur !== 1'b1)       begin errors++; $display("FAIL reset_bit_cur: got %b expected 1", bit_cur); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (txif.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", txif.tx_ready); end
    checks++; if (phase !== 16'h0000)     begin errors++; $display("FAIL reset_phase: got %h expected 0000", phase); end
    checks++; if (fsk_out !== 1'b0)       begin errors++; $display("FAIL reset_fsk: got %b expected 0", fsk_out); end
    repeat (2) @(posedge mainclk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    int bad_ph = 0;
    vec_bad = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (s_vec[15:0] !== 16'(i * 4096) || s_vec[16] !== ((i / 8) % 2 == 1)) bad_ph++;
    end
    checks++; if (bad_ph !== 0)  begin errors++; $display("FAIL idle_phase_steps: got %0d bad cycles expected 0", bad_ph); end
    checks++; if (vec_bad !== 0) begin errors++; $display("FAIL idle_model: got %0d bad cycles expected 0", vec_bad); end
  endtask

  task automatic test_single(input logic [7:0] b, input string nm);
    logic [9:0] syms;
    int rl, bn;
    vec_bad = 0;
    send(b);
    capture(syms, rl, bn);
    checks++; if (syms !== {1'b1, b, 1'b0}) begin errors++; $display("FAIL %s_symbols: got %b expected %b", nm, syms, {1'b1, b, 1'b0}); end
    checks++; if (rl !== FRAME - 1) begin errors++; $display("FAIL %s_ready_low: got %0d expected %0d", nm, rl, FRAME - 1); end
    checks++; if (bn !== FRAME)     begin errors++; $display("FAIL %s_busy_len: got %0d expected %0d", nm, bn, FRAME); end
    checks++; if (vec_bad !== 0)    begin errors++; $display("FAIL %s_model: got %0d bad cycles expected 0", nm, vec_bad); end
  endtask

  task automatic test_wrap();
    int found = 0;
    vec_bad = 0;
    send(8'($urandom));
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick();
      if (s_vec[15:0] == 16'hF800 && s_vec[19] == 1'b0) begin
        tick();
        found = 1;
        checks++; if (s_vec[15:0] !== 16'h0000) begin errors++; $display("FAIL wrap_phase: got %h expected 0000", s_vec[15:0]); end
      end
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL wrap_reached: got %0d expected 1", found); end
    for (int i = 0; i < FRAME; i++) tick();
    checks++; if (vec_bad !== 0) begin errors++; $display("FAIL wrap_model: got %0d bad cycles expected 0", vec_bad); end
  endtask

  task automatic test_random();
    vec_bad = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      txif.tx_valid = ($urandom_range(0, 40) == 0);
      txif.tx_data  = 8'($urandom);
      tick();
    end
    txif.tx_valid = 1'b0;
    for (int i = 0; i < FRAME + 10; i++) tick();
    checks++; if (vec_bad !== 0) begin errors++; $display("FAIL random_model: got %0d bad cycles expected 0", vec_bad); end
  endtask

  task automatic test_back_to_back();
    int t0 = -1, t1 = -1;
    logic prev = 1'b1, rdy_before = 1'b0, prev_rdy = 1'b0;
    vec_bad = 0;
    txif.tx_valid = 1'b1;
    txif.tx_data  = 8'h00;
    for (int i = 0; i < 3 * FRAME && t1 < 0; i++) begin
      tick();
      if (prev && !s_vec[19]) begin
        if (t0 < 0) begin
          t0 = i;
          txif.tx_data = 8'hFF;
        end else begin
          t1 = i;
          rdy_before = prev_rdy;
        end
      end
      prev = s_vec[19];
      prev_rdy = s_vec[17];
    end
    txif.tx_valid = 1'b0;
    for (int i = 0; i < FRAME + 10; i++) tick();
    checks++; if (t1 - t0 !== FRAME) begin errors++; $display("FAIL b2b_pitch: got %0d expected %0d", t1 - t0, FRAME); end
    checks++; if (rdy_before !== 1'b1) begin errors++; $display("FAIL b2b_ready_last_stop: got %b expected 1", rdy_before); end
    checks++; if (vec_bad !== 0) begin errors++; $display("FAIL b2b_model: got %0d bad cycles expected 0", vec_bad); end
  endtask

  task automatic test_ignore();
    logic [7:0] b;
    logic [9:0] syms = '0;
    int extra = 0;
    vec_bad = 0;
    b = 8'($urandom);
    if (b == 8'h3C) b = 8'h5A;
    send(b);
    for (int i = 0; i < FRAME + 2 * BITC; i++) begin
      txif.tx_valid = (i == 1000);
      txif.tx_data  = (i == 1000) ? 8'h3C : 8'($urandom);
      tick();
      if (i < FRAME && (i % BITC) == BITC / 2) syms[i / BITC] = s_vec[19];
      if (i >= FRAME && s_vec[18]) extra++;
    end
    txif.tx_valid = 1'b0;
    checks++; if (syms !== {1'b1, b, 1'b0}) begin errors++; $display("FAIL ignore_symbols: got %b expected %b", syms, {1'b1, b, 1'b0}); end
    checks++; if (extra !== 0)   begin errors++; $display("FAIL ignore_no_second_frame: got %0d busy cycles expected 0", extra); end
    checks++; if (vec_bad !== 0) begin errors++; $display("FAIL ignore_model: got %0d bad cycles expected 0", vec_bad); end
  endtask

  task automatic test_reset_mid();
    vec_bad = 0;
    send(8'($urandom));
    for (int i = 0; i < BITC + 4 * BITC + 100; i++) tick();
    checks++; if (s_vec[18] !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", s_vec[18]); end
    reset = 1'b1;
    #1;
    checks++; if ({bit_cur, busy, txif.tx_ready, fsk_out, phase} !== {4'b1010, 16'h0000})
      begin errors++; $display("FAIL midrst_outputs: got %h expected %h", {bit_cur, busy, txif.tx_ready, fsk_out, phase}, {4'b1010, 16'h0000}); end
    model_reset();
    @(posedge mainclk);
    #1;
    reset = 1'b0;
    checks++; if (vec_bad !== 0) begin errors++; $display("FAIL midrst_model: got %0d bad cycles expected 0", vec_bad); end
    test_single(8'($urandom), "after_reset");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single(8'hA5, "a5");
    test_wrap();
    test_random();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
